// File: rtl/rv_soc_pkg.sv
// Shared SoC constants and helpers used by the board-level input path.
package rv_soc_pkg;

  localparam int RV_GPIO_IN_WIDTH   = 21;
  localparam int RV_DEBOUNCE_CYCLES = 500000;

  // Counter width is max(1, clog2(cycles)), so it reaches cycles-1 without wrapping.
  function automatic int rv_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rv_debounce_bit.sv
// One debounced input: two-flop synchronizer, stability counter, stable level.
// Edge pulses are built only when RV_DEBOUNCE_EDGE_EN is defined; otherwise rise/fall read 0.
module rv_debounce_bit
  import rv_soc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = RV_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic data,
  output logic rise,
  output logic fall
);

  localparam int             CW      = rv_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any agreement restarts the window; a full run of disagreement commits.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data = stable_q;

`ifdef RV_DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Registered alongside stable so the pulse coincides with the new level.
  always_comb begin
    rise_d = stable_d & ~stable_q;
    fall_d = ~stable_d & stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/rv_input_debounce.sv
// Debounces board switches/buttons into the SoC i_data input, one independent lane per bit.
// Edge pulses on o_rise/o_fall require RV_DEBOUNCE_EDGE_EN; without it those ports read 0.
module rv_input_debounce
  import rv_soc_pkg::*;
#(
  parameter int WIDTH           = RV_GPIO_IN_WIDTH,
  parameter int DEBOUNCE_CYCLES = RV_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    rv_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .raw  (i_raw[gi]),
      .data (o_data[gi]),
      .rise (o_rise[gi]),
      .fall (o_fall[gi])
    );
  end

endmodule

// File: tb/tb_rv_input_debounce.sv
// Cycle-accurate bench for rv_input_debounce (WIDTH=21, DEBOUNCE_CYCLES=4) using a per-cycle scoreboard.
module tb_rv_input_debounce;

  localparam int W = 21;
  localparam int D = 4;
`ifdef RV_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] data;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           n;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           id;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] i_raw;
  logic [W-1:0] o_data;
  logic [W-1:0] o_rise;
  logic [W-1:0] o_fall;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t chk_e;
  int   cyc;
  int   n_tests;
  int   n_fail;

  rv_input_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .i_raw (i_raw),
    .o_data(o_data),
    .o_rise(o_rise),
    .o_fall(o_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] data,
                     input logic [W-1:0] rise, input logic [W-1:0] fall, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.data = data; v.rise = rise; v.fall = fall; v.n = n;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs and queue what the outputs must be after the next edge.
  task automatic drive(input logic rst, input logic [W-1:0] raw, input logic [W-1:0] data,
                       input logic [W-1:0] rise, input logic [W-1:0] fall);
    exp_t e;
    @(negedge clk);
    reset = rst;
    i_raw = raw;
    e.data = data;
    e.rise = EDGE_EN ? rise : '0;
    e.fall = EDGE_EN ? fall : '0;
    e.id   = cyc;
    cyc++;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int id, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %06h, want %06h", name, id, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      chk_e = sb.pop_front();
      check("o_data", chk_e.id, o_data, chk_e.data);
      check("o_rise", chk_e.id, o_rise, chk_e.rise);
      check("o_fall", chk_e.id, o_fall, chk_e.fall);
      $display("[TB] cycle %0d rst=%0b raw=%06h data=%06h rise=%06h fall=%06h",
               chk_e.id, reset, i_raw, o_data, o_rise, o_fall);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] base;
    reset   = 1'b1;
    i_raw   = '0;
    cyc     = 0;
    n_tests = 0;
    n_fail  = 0;

    // rst, raw, data, rise, fall, cycles
    add(1, 21'h000000, 21'h000000, 21'h0, 21'h0, 2);        // reset state
    add(0, 21'h000001, 21'h000000, 21'h0, 21'h0, 5);        // clean rise on bit 0
    add(0, 21'h000001, 21'h000001, 21'h000001, 21'h0, 1);
    add(0, 21'h000001, 21'h000001, 21'h0, 21'h0, 3);
    add(0, 21'h000009, 21'h000001, 21'h0, 21'h0, 3);        // 3-cycle glitch on bit 3
    add(0, 21'h000001, 21'h000001, 21'h0, 21'h0, 6);
    add(0, 21'h000011, 21'h000001, 21'h0, 21'h0, 4);        // exactly-D pulse on bit 4
    add(0, 21'h000001, 21'h000001, 21'h0, 21'h0, 1);
    add(0, 21'h000001, 21'h000011, 21'h000010, 21'h0, 1);
    add(0, 21'h000001, 21'h000011, 21'h0, 21'h0, 3);
    add(0, 21'h000001, 21'h000001, 21'h0, 21'h000010, 1);
    add(0, 21'h000001, 21'h000001, 21'h0, 21'h0, 2);
    add(0, 21'h000005, 21'h000001, 21'h0, 21'h0, 5);        // bit 2 up
    add(0, 21'h000005, 21'h000005, 21'h000004, 21'h0, 1);
    add(0, 21'h000005, 21'h000005, 21'h0, 21'h0, 3);
    add(0, 21'h000001, 21'h000005, 21'h0, 21'h0, 5);        // bit 2 down
    add(0, 21'h000001, 21'h000001, 21'h0, 21'h000004, 1);
    add(0, 21'h000001, 21'h000001, 21'h0, 21'h0, 3);
    add(0, 21'h0000C0, 21'h000001, 21'h0, 21'h0, 5);        // simultaneous rise/fall
    add(0, 21'h0000C0, 21'h0000C0, 21'h0000C0, 21'h000001, 1);
    add(0, 21'h0000C0, 21'h0000C0, 21'h0, 21'h0, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        drive(vecs[i].rst, vecs[i].raw, vecs[i].data, vecs[i].rise, vecs[i].fall);
      end
    end

    // Bit 5 chatters with 2-cycle phases, then holds high: only the hold commits.
    base = 21'h0000C0;
    for (int p = 0; p < 10; p++) begin
      repeat (2) drive(0, base | 21'h000020, base, '0, '0);
      repeat (2) drive(0, base, base, '0, '0);
    end
    repeat (5) drive(0, base | 21'h000020, base, '0, '0);
    drive(0, base | 21'h000020, base | 21'h000020, 21'h000020, '0);
    repeat (3) drive(0, base | 21'h000020, base | 21'h000020, '0, '0);

    // All ones, reset hits mid-count, then a full window from release.
    base = 21'h0000E0;
    repeat (3) drive(0, 21'h1FFFFF, base, '0, '0);
    drive(1, 21'h1FFFFF, '0, '0, '0);
    repeat (5) drive(0, 21'h1FFFFF, '0, '0, '0);
    drive(0, 21'h1FFFFF, 21'h1FFFFF, 21'h1FFFFF, '0);
    repeat (3) drive(0, 21'h1FFFFF, 21'h1FFFFF, '0, '0);
    repeat (2) drive(1, '0, '0, '0, '0);

    @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_input_debounce.md
RV_INPUT_DEBOUNCE -- requirements
Module: rv_input_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 21: number of switch/button inputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stability window in clk cycles; legal values 1 and above.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_raw, input, WIDTH bits: asynchronous board switches/buttons.
REQ-006 SHALL have port o_data, output, WIDTH bits: debounced level that feeds the SoC i_data input.
REQ-007 SHALL have port o_rise, output, WIDTH bits: one-cycle pulse per bit on a debounced 0->1 transition.
REQ-008 SHALL have port o_fall, output, WIDTH bits: one-cycle pulse per bit on a debounced 1->0 transition.

Function
REQ-009 SHALL pass each i_raw bit through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-010 SHALL keep, per bit, a registered stable level (drives o_data) and a counter of width max(1, clog2(DEBOUNCE_CYCLES)).
REQ-011 SHALL clear the bit's counter on any edge where sync2 equals stable.
REQ-012 SHALL, on an edge where sync2 differs from stable and counter < DEBOUNCE_CYCLES-1, increment the counter.
REQ-013 SHALL, on an edge where sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, load sync2 into stable and clear the counter.
REQ-014 SHALL, for a clean input step first sampled at edge 0 and held, change o_data at edge DEBOUNCE_CYCLES+1 (latency DEBOUNCE_CYCLES+2 edges).
REQ-015 SHALL leave o_data unchanged for any sync2 disagreement lasting fewer than DEBOUNCE_CYCLES consecutive edges; the counter restarts from 0 at the next disagreement.
REQ-016 SHALL assert o_rise[i] (resp. o_fall[i]) as a registered pulse for exactly the cycle in which o_data[i] first shows the new value.
REQ-017 SHALL treat all bits independently; simultaneous transitions on several bits each follow REQ-011..016 without interaction.
REQ-018 SHALL never let the counter wrap; the maximum count reached is DEBOUNCE_CYCLES-1.
REQ-019 SHALL, with DEBOUNCE_CYCLES=1, update o_data on the first edge where sync2 differs from stable.

Reset
REQ-020 SHALL, on any edge with reset high, clear sync1, sync2, stable, counters, o_rise and o_fall to 0, including mid-count.
REQ-021 SHALL, after reset release with an input held at 1, raise o_data and pulse o_rise at release edge + DEBOUNCE_CYCLES+1.

Configuration
REQ-022 SHALL compile the edge-pulse logic only when macro RV_DEBOUNCE_EDGE_EN is defined.
REQ-023 SHALL, without RV_DEBOUNCE_EDGE_EN, keep the o_rise/o_fall ports, tie them to 0, and leave o_data behaviour unchanged.

Structure
REQ-024 SHALL take default values for WIDTH and DEBOUNCE_CYCLES from shared package rv_soc_pkg (constants RV_GPIO_IN_WIDTH, RV_DEBOUNCE_CYCLES).
REQ-025 SHALL instantiate WIDTH copies of sub-module rv_debounce_bit (synchronizer, counter, stable and edge registers for one bit) via a generate loop.
REQ-026 SHALL be instantiated in the board top between the input pins and the SoC i_data input, clocked by the SoC clock.

Verification (WIDTH=21, DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover: i_raw[0] 0->1 held -> o_data[0]=1 at edge 5, o_rise[0] high that one cycle only, other bits 0.
REQ-028 SHALL cover: i_raw[3] high pulse for 3 cycles, then low -> o_data[3] stays 0; o_rise/o_fall stay 0.
REQ-029 SHALL cover: i_raw[5] toggled every 2 cycles for 40 cycles, then held 1 -> o_data[5] rises exactly 6 edges after the final hold begins.
REQ-030 SHALL cover: i_raw=0x1FFFFF held, reset asserted mid-count at edge 3 for one cycle -> o_data=0 during reset, 0x1FFFFF at release edge+5, with all o_rise bits pulsing together.
REQ-031 SHALL cover: o_data[2]=1 stable, then i_raw[2]->0 held -> o_fall[2] pulses once at edge 5 and o_data[2]=0.
REQ-032 SHALL cover: build without RV_DEBOUNCE_EDGE_EN, repeat REQ-027 -> identical o_data timing, o_rise=o_fall=0 throughout.
